mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one data-memory port between CORES_NUM Core instances using round-robin arbitration.
//   Each core's enable_M/addr_M/wr_data_M/rd_data_M/ready_M port lands on one requester slot.
//   The winner's transaction goes to memory; the memory ready pulse returns only to that core.
//   Sits between the core array and the shared memory / memory model.
// PARAMETERS
//   CORES_NUM  4  number of requester slots; any value >= 2; pointer width = $clog2(CORES_NUM)
//   REG_SIZE   8  data width, same as `REG_RANGE
//   ADDR_SIZE  8  address width, same as `ADDR_RANGE
// PORTS
//   clk           in   1                    clock; all logic on posedge
//   reset         in   1                    synchronous, active-high
//   core_enable   in   2*CORES_NUM          per core {wr,rd}; slot i at [2i+1:2i]; bit0=read, bit1=write
//   core_addr     in   ADDR_SIZE*CORES_NUM  per-core address, slot i at [(i+1)*ADDR_SIZE-1 : i*ADDR_SIZE]
//   core_wr_data  in   REG_SIZE*CORES_NUM   per-core write data, same packing
//   core_rd_data  out  REG_SIZE             read data, broadcast to all cores; valid when core_ready[i]
//   core_ready    out  CORES_NUM            one-hot; completion pulse to the granted core
//   mem_enable    out  2                    {wr,rd} to memory, registered
//   mem_addr      out  ADDR_SIZE            registered
//   mem_wr_data   out  REG_SIZE             registered
//   mem_rd_data   in   REG_SIZE             memory read data, valid with mem_ready
//   mem_ready     in   1                    memory completion; sampled only in BUSY
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0, core_ready=0, core_rd_data=0, mem_enable=0, mem_addr=0, mem_wr_data=0.
//     Reset is synchronous. It aborts any in-flight transaction; no ready goes to any core.
//   Requests: slot i requests while core_enable[2i+1:2i] != 0.
//     2'b11 is executed as a write; the read bit is ignored.
//   FSM IDLE -> BUSY -> RESP -> IDLE:
//     IDLE: search for a requester from rr_ptr upward, wrapping modulo CORES_NUM.
//       If one is found, latch grant=i plus that slot's enable/addr/wr_data into the mem_* registers; go to BUSY.
//       If none is found, stay in IDLE with mem_enable=0.
//     BUSY: mem_* outputs stay constant; core inputs are ignored.
//       On mem_ready=1: capture mem_rd_data into core_rd_data (reads only), clear mem_enable, go to RESP.
//       Stay in BUSY indefinitely until mem_ready; there is no timeout.
//     RESP: core_ready[grant]=1 for exactly this one cycle; rr_ptr <= (grant+1) mod CORES_NUM; go to IDLE.
//   Latency: request sampled at edge k -> mem_enable high from k+1.
//     mem_ready sampled at edge m -> core_ready high in cycle m+1 -> IDLE at m+2.
//     Minimum request-to-ready time is 2 cycles.
//   Requester rule: the core holds enable/addr/wr_data stable until it samples core_ready high.
//     A request still asserted in the IDLE cycle after RESP counts as a new request.
//     It is served only in round-robin turn after the other slots.
//   Fairness: with all slots requesting continuously, grants go 0,1,2,...,N-1,0.
//     No slot waits longer than CORES_NUM-1 transactions.
//   A write leaves core_rd_data unchanged. core_rd_data holds its value between transactions.
//   mem_ready in IDLE or RESP is ignored.
//   A requester dropping enable during BUSY does not cancel the transaction; ready is still pulsed.
// TESTING
//   1. Reset, slot 2 read addr=0x10; memory returns 0xA5 with ready 2 cycles after mem_enable.
//      -> mem_enable=01, mem_addr=0x10; core_ready=0100 for one cycle; core_rd_data=0xA5.
//   2. All 4 slots request continuously.
//      -> grant order 0,1,2,3,0; core_ready never more than one bit high; never two in consecutive cycles.
//   3. Slot 1 write addr=0x20, data=0x3C; slot 3 read at the same time; rr_ptr=0.
//      -> slot 1 first with mem_enable=10, mem_wr_data=0x3C; then slot 3 read; core_rd_data unchanged by the write.
//   4. core_enable=11 on slot 0.
//      -> mem_enable=10 (executed as a write).
//      mem_ready pulsed while IDLE -> no core_ready, state stays IDLE.
//   5. reset asserted in BUSY with mem_enable=01.
//      -> next cycle all outputs 0, IDLE, rr_ptr=0; no core_ready; the request is re-served after reset.
//   6. Memory stalls 20 cycles in BUSY while other slots request.
//      -> mem_* outputs stable throughout; grant does not change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one data-memory port among CORES_NUM requester slots.
// IDLE picks the next requester, BUSY waits for the memory, RESP pulses ready to the winner.
module mem_port_arbiter #(
  parameter int CORES_NUM = 4,
  parameter int REG_SIZE  = 8,
  parameter int ADDR_SIZE = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [2*CORES_NUM-1:0]         core_enable,
  input  logic [ADDR_SIZE*CORES_NUM-1:0] core_addr,
  input  logic [REG_SIZE*CORES_NUM-1:0]  core_wr_data,
  output logic [REG_SIZE-1:0]            core_rd_data,
  output logic [CORES_NUM-1:0]           core_ready,
  output logic [1:0]                     mem_enable,
  output logic [ADDR_SIZE-1:0]           mem_addr,
  output logic [REG_SIZE-1:0]            mem_wr_data,
  input  logic [REG_SIZE-1:0]            mem_rd_data,
  input  logic                           mem_ready
);

  localparam int PTR_W = (CORES_NUM > 1) ? $clog2(CORES_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     grant_q, grant_d;
  logic [1:0]           mem_enable_q, mem_enable_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [REG_SIZE-1:0]  mem_wr_data_q, mem_wr_data_d;
  logic [REG_SIZE-1:0]  core_rd_data_q, core_rd_data_d;
  logic [CORES_NUM-1:0] core_ready_q, core_ready_d;

  logic [CORES_NUM-1:0] req_s;
  logic                 found_s;
  logic [PTR_W-1:0]     pick_s;
  logic [PTR_W-1:0]     cand_s;
  logic [1:0]           sel_en_s;
  logic [ADDR_SIZE-1:0] sel_addr_s;
  logic [REG_SIZE-1:0]  sel_wdata_s;

  always_comb begin
    for (int i = 0; i < CORES_NUM; i++) begin
      req_s[i] = |core_enable[2*i +: 2];
    end
  end

  // First requester at or after rr_ptr, wrapping modulo CORES_NUM.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    for (int k = 0; k < CORES_NUM; k++) begin
      cand_s = PTR_W'((int'(rr_ptr_q) + k) % CORES_NUM);
      if (!found_s && req_s[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end
    end
  end

  always_comb begin
    sel_en_s    = 2'b00;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int i = 0; i < CORES_NUM; i++) begin
      if (PTR_W'(i) == pick_s) begin
        sel_en_s    = core_enable[2*i +: 2];
        sel_addr_s  = core_addr[i*ADDR_SIZE +: ADDR_SIZE];
        sel_wdata_s = core_wr_data[i*REG_SIZE +: REG_SIZE];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    mem_enable_d   = mem_enable_q;
    mem_addr_d     = mem_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    core_rd_data_d = core_rd_data_q;
    core_ready_d   = '0;
    case (state_q)
      S_IDLE: begin
        mem_enable_d = 2'b00;
        if (found_s) begin
          grant_d       = pick_s;
          // A simultaneous read+write request is executed as a write.
          mem_enable_d  = sel_en_s[1] ? 2'b10 : 2'b01;
          mem_addr_d    = sel_addr_s;
          mem_wr_data_d = sel_wdata_s;
          state_d       = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          if (mem_enable_q == 2'b01) begin
            core_rd_data_d = mem_rd_data;
          end else begin
            core_rd_data_d = core_rd_data_q;
          end
          mem_enable_d = 2'b00;
          core_ready_d = {{(CORES_NUM-1){1'b0}}, 1'b1} << grant_q;
          state_d      = S_RESP;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_RESP: begin
        rr_ptr_d = (grant_q == PTR_W'(CORES_NUM-1)) ? '0 : grant_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      mem_enable_q   <= 2'b00;
      mem_addr_q     <= '0;
      mem_wr_data_q  <= '0;
      core_rd_data_q <= '0;
      core_ready_q   <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      mem_enable_q   <= mem_enable_d;
      mem_addr_q     <= mem_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      core_rd_data_q <= core_rd_data_d;
      core_ready_q   <= core_ready_d;
    end
  end

  assign core_rd_data = core_rd_data_q;
  assign core_ready   = core_ready_q;
  assign mem_enable   = mem_enable_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wr_data  = mem_wr_data_q;

endmodule
